// File: rtl/shacc_seq.sv
// Sequencer for the shifter-accumulator in bit-serial MAC mode. For one output it walks the
// weight bit-planes from MSB to LSB and every tile within each plane. It drives the accumulator
// controls and the operand-fetch indices, and flags when the accumulator holds the dot product.
module shacc_seq #(
  parameter int unsigned PW = 4,
  parameter int unsigned TW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [PW-1:0] cfg_prec_i,
  input  logic [TW-1:0] cfg_tiles_i,
  input  logic          cfg_signed_i,
  input  logic          stall_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          out_valid_o,
  output logic          clr_o,
  output logic          load_o,
  output logic          acc_o,
  output logic          sh_o,
  output logic          neg_o,
  output logic [PW-1:0] bit_idx_o,
  output logic [TW-1:0] tile_idx_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prec_q, prec_d;
  logic [TW-1:0] tiles_q, tiles_d;
  logic          signed_q, signed_d;
  logic [PW-1:0] bit_q, bit_d;
  logic [TW-1:0] tile_q, tile_d;

  logic          run;
  logic          beat;
  logic          first_beat;
  logic          plane_end;
  logic          last_beat;
  logic [PW-1:0] prec_eff;
  logic [TW-1:0] tiles_eff;

  // Shared decode of the registered counters; a zero config means one plane / one tile.
  always_comb begin
    run        = (state_q == StRun);
    beat       = run && !stall_i && !abort_i;
    first_beat = (bit_q == prec_q - PW'(1)) && (tile_q == '0);
    plane_end  = (tile_q == tiles_q - TW'(1));
    last_beat  = (bit_q == '0) && plane_end;
    prec_eff   = (cfg_prec_i == '0) ? PW'(1) : cfg_prec_i;
    tiles_eff  = (cfg_tiles_i == '0) ? TW'(1) : cfg_tiles_i;
  end

  // Next-state: start acceptance, counter advance on beats, abort back to idle.
  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    tiles_d  = tiles_q;
    signed_d = signed_q;
    bit_d    = bit_q;
    tile_d   = tile_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (start_i) begin
          state_d  = StRun;
          prec_d   = prec_eff;
          tiles_d  = tiles_eff;
          signed_d = cfg_signed_i;
          bit_d    = prec_eff - PW'(1);
          tile_d   = '0;
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (beat) begin
          if (last_beat) begin
            // Counters hold on the final beat so they never underflow.
            state_d = StDone;
          end else if (plane_end) begin
            tile_d = '0;
            bit_d  = bit_q - PW'(1);
          end else begin
            tile_d = tile_q + TW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator control decode; load/acc/sh only on beats, neg stays up through stalls.
  always_comb begin
    busy_o      = run;
    done_o      = (state_q == StDone);
    out_valid_o = (state_q == StDone);
    clr_o       = run && abort_i;
    load_o      = beat && first_beat;
    acc_o       = beat && !first_beat;
    sh_o        = beat && !first_beat && (tile_q == '0);
    neg_o       = run && signed_q && (bit_q == prec_q - PW'(1));
    bit_idx_o   = bit_q;
    tile_idx_o  = tile_q;
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      prec_q   <= '0;
      tiles_q  <= '0;
      signed_q <= 1'b0;
      bit_q    <= '0;
      tile_q   <= '0;
    end else begin
      state_q  <= state_d;
      prec_q   <= prec_d;
      tiles_q  <= tiles_d;
      signed_q <= signed_d;
      bit_q    <= bit_d;
      tile_q   <= tile_d;
    end
  end

endmodule
